// File: rtl/pwm_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_frame_sequencer                                                      |
// | Frame timebase, throttle command shadowing and arm/failsafe gating for   |
// | a bank of PWM generators.                                                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pwm_frame_sequencer #(
  parameter int INPUT_BIT_WIDTH = 10,
  parameter int NUM_MOTORS      = 4,
  parameter int PWM_PERIOD_US   = 20000,
  parameter int MIN_HIGH_US     = 1000,
  parameter int MAX_HIGH_US     = 2000,
  parameter int ARM_FRAMES      = 50,
  parameter int TIMEOUT_FRAMES  = 25
) (
  input  logic                                  us_clk,
  input  logic                                  resetn,
  input  logic [NUM_MOTORS*INPUT_BIT_WIDTH-1:0] cmd_vals,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic                                  arm_req,
  output logic [15:0]                           period_counter,
  output logic [INPUT_BIT_WIDTH-1:0]            high_counter,
  output logic [NUM_MOTORS*INPUT_BIT_WIDTH-1:0] motor_vals,
  output logic                                  frame_start,
  output logic [1:0]                            arm_state
);

  localparam int                         c_bus_w      = NUM_MOTORS * INPUT_BIT_WIDTH;
  localparam logic [15:0]                c_period     = 16'(PWM_PERIOD_US);
  localparam logic [15:0]                c_min_high   = 16'(MIN_HIGH_US);
  localparam logic [INPUT_BIT_WIDTH-1:0] c_span       = INPUT_BIT_WIDTH'(MAX_HIGH_US - MIN_HIGH_US);
  localparam logic [INPUT_BIT_WIDTH-1:0] c_one        = INPUT_BIT_WIDTH'(1);
  localparam logic [15:0]                c_arm_frames = 16'(ARM_FRAMES);
  localparam logic [15:0]                c_timeout    = 16'(TIMEOUT_FRAMES);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAILSAFE = 2'd3
  } arm_state_e;

  logic [15:0]                r_period_counter;
  logic [15:0]                w_pc_next;
  logic [INPUT_BIT_WIDTH-1:0] r_high_counter;
  logic [INPUT_BIT_WIDTH-1:0] w_hc_next;
  logic                       w_boundary;

  logic [c_bus_w-1:0]         w_cmd_clamped;
  logic [c_bus_w-1:0]         r_shadow;
  logic [c_bus_w-1:0]         r_active;
  logic [c_bus_w-1:0]         w_active_next;
  logic [c_bus_w-1:0]         r_motor_vals;
  logic                       r_pending;
  logic                       w_xfer;
  logic                       w_fresh;

  arm_state_e                 r_state;
  arm_state_e                 w_state_next;
  logic [15:0]                r_arm_cnt;
  logic [15:0]                w_arm_cnt_next;
  logic [15:0]                r_stale_cnt;
  logic [15:0]                w_stale_cnt_next;

  // Timebase: 0 only straight out of reset, then 1..PWM_PERIOD_US repeating.
  assign w_boundary = (r_period_counter == c_period);
  assign w_pc_next  = w_boundary ? 16'd1 : (r_period_counter + 16'd1);

  always_comb begin
    w_hc_next = '0;
    if (w_pc_next <= c_min_high) begin
      w_hc_next = '0;
    end else if (r_high_counter == c_span) begin
      w_hc_next = c_span;
    end else begin
      w_hc_next = r_high_counter + c_one;
    end
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_period_counter <= '0;
      r_high_counter   <= '0;
    end else begin
      r_period_counter <= w_pc_next;
      r_high_counter   <= w_hc_next;
    end
  end

  for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_clamp
    assign w_cmd_clamped[i*INPUT_BIT_WIDTH +: INPUT_BIT_WIDTH] =
      (cmd_vals[i*INPUT_BIT_WIDTH +: INPUT_BIT_WIDTH] > c_span) ?
        c_span : cmd_vals[i*INPUT_BIT_WIDTH +: INPUT_BIT_WIDTH];
  end

  // A single shadow slot: a second command stalls until the boundary drains it.
  assign cmd_ready     = resetn && !r_pending;
  assign w_xfer        = cmd_valid && cmd_ready;
  assign w_fresh       = w_boundary && r_pending;
  assign w_active_next = w_fresh ? r_shadow : r_active;

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else if (w_fresh) begin
      r_active  <= r_shadow;
      r_pending <= 1'b0;
    end else if (w_xfer) begin
      r_shadow  <= w_cmd_clamped;
      r_pending <= 1'b1;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_arm_cnt_next   = r_arm_cnt;
    w_stale_cnt_next = r_stale_cnt;
    if (w_boundary) begin
      case (r_state)
        ST_DISARMED: begin
          if (arm_req) begin
            w_state_next   = ST_ARMING;
            w_arm_cnt_next = '0;
          end
        end
        ST_ARMING: begin
          if (!arm_req) begin
            w_state_next = ST_DISARMED;
          end else begin
            w_arm_cnt_next = r_arm_cnt + 16'd1;
            if (w_arm_cnt_next == c_arm_frames) begin
              w_state_next     = ST_ARMED;
              w_stale_cnt_next = '0;
            end
          end
        end
        ST_ARMED: begin
          if (!arm_req) begin
            w_state_next = ST_DISARMED;
          end else if (w_fresh) begin
            w_stale_cnt_next = '0;
          end else begin
            w_stale_cnt_next = r_stale_cnt + 16'd1;
            if (w_stale_cnt_next == c_timeout) begin
              w_state_next = ST_FAILSAFE;
            end
          end
        end
        ST_FAILSAFE: begin
          if (!arm_req) begin
            w_state_next = ST_DISARMED;
          end
        end
        default: w_state_next = ST_DISARMED;
      endcase
    end
  end

  // Motor values move only at the boundary so no generator sees a mid-pulse change.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_DISARMED;
      r_arm_cnt    <= '0;
      r_stale_cnt  <= '0;
      r_motor_vals <= '0;
    end else begin
      r_state     <= w_state_next;
      r_arm_cnt   <= w_arm_cnt_next;
      r_stale_cnt <= w_stale_cnt_next;
      if (w_boundary) begin
        r_motor_vals <= (w_state_next == ST_ARMED) ? w_active_next : '0;
      end
    end
  end

  assign period_counter = r_period_counter;
  assign high_counter   = r_high_counter;
  assign motor_vals     = r_motor_vals;
  assign frame_start    = w_boundary;
  assign arm_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pwm_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pwm_frame_sequencer                                                   |
// | Scoreboard bench: boundary expectations queued by stimulus, popped by a  |
// | frame monitor. Revision: 1.0                                             |
// +--------------------------------------------------------------------------+
module tb_pwm_frame_sequencer;

  localparam int IBW  = 10;
  localparam int NM   = 4;
  localparam int P    = 700;
  localparam int MINH = 100;
  localparam int MAXH = 600;
  localparam int SPAN = MAXH - MINH;
  localparam int ARMF = 3;
  localparam int TOF  = 2;

  logic              us_clk;
  logic              resetn;
  logic [NM*IBW-1:0] cmd_vals;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              arm_req;
  logic [15:0]       period_counter;
  logic [IBW-1:0]    high_counter;
  logic [NM*IBW-1:0] motor_vals;
  logic              frame_start;
  logic [1:0]        arm_state;

  pwm_frame_sequencer #(
    .INPUT_BIT_WIDTH(IBW), .NUM_MOTORS(NM), .PWM_PERIOD_US(P),
    .MIN_HIGH_US(MINH), .MAX_HIGH_US(MAXH), .ARM_FRAMES(ARMF), .TIMEOUT_FRAMES(TOF)
  ) dut (
    .us_clk(us_clk), .resetn(resetn), .cmd_vals(cmd_vals), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .arm_req(arm_req), .period_counter(period_counter),
    .high_counter(high_counter), .motor_vals(motor_vals), .frame_start(frame_start),
    .arm_state(arm_state)
  );

  initial us_clk = 1'b0;
  always #5 us_clk = ~us_clk;

  typedef struct {
    int          frame;
    logic [1:0]  st;
    logic [39:0] mv;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   bnum  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  task automatic push(input int frame, input logic [1:0] st, input logic [39:0] mv);
    exp_t e;
    e.frame = frame;
    e.st    = st;
    e.mv    = mv;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge us_clk);
    #1;
  endtask

  task automatic goto_pc(input int v);
    int n = 0;
    while (period_counter != 16'(v) && n < 2 * P + 4) begin
      step();
      n++;
    end
    if (period_counter != 16'(v)) begin
      total++;
      bad++;
      $display("FAIL goto_pc: got %0d expected %0d", period_counter, v);
    end
  endtask

  task automatic wait_bnum(input int t);
    int n = 0;
    while (bnum < t && n < 8 * P) begin
      step();
      n++;
    end
    if (bnum < t) begin
      total++;
      bad++;
      $display("FAIL wait_boundary: got %0d expected %0d", bnum, t);
    end
  endtask

  task automatic send(input string name, input logic [39:0] v);
    check(name, 64'(cmd_ready), 64'd1);
    cmd_vals  = v;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_pc"}, 64'(period_counter), 64'd0);
    check({tag, "_hc"}, 64'(high_counter), 64'd0);
    check({tag, "_mv"}, 64'(motor_vals), 64'd0);
    check({tag, "_fs"}, 64'(frame_start), 64'd0);
    check({tag, "_state"}, 64'(arm_state), 64'd0);
    check({tag, "_ready"}, 64'(cmd_ready), 64'd0);
  endtask

  // Monitor: each frame_start is a boundary; the applied result is sampled one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge us_clk);
      if (frame_start === 1'b1) begin
        bnum++;
        @(negedge us_clk);
        while (exp_q.size() > 0 && exp_q[0].frame <= bnum) begin
          e = exp_q.pop_front();
          check($sformatf("frame%0d_state", e.frame), 64'(arm_state), 64'(e.st));
          check($sformatf("frame%0d_mv", e.frame), 64'(motor_vals), 64'(e.mv));
        end
      end
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    logic [39:0] v2, va, vb, vbc, vc, vd, ve;
    int b, n, m, r, k, exp_pc, exp_hc;

    v2  = pack4(450, 120, 37, 500);
    va  = pack4(300, 301, 302, 303);
    vb  = pack4(10, 20, 1023, 501);
    vbc = pack4(10, 20, SPAN, SPAN);
    vc  = pack4(400, 400, 400, 400);
    vd  = pack4(11, 22, 33, 44);
    ve  = pack4(1, 2, 3, 4);

    resetn = 1'b0; cmd_valid = 1'b0; arm_req = 1'b0; cmd_vals = '0;
    repeat (3) @(posedge us_clk);
    #1;
    check_zero_outputs("reset");
    resetn = 1'b1;
    #1;
    check("release_ready", 64'(cmd_ready), 64'd1);
    check("release_pc", 64'(period_counter), 64'd0);

    // T1: idle timebase over two frames
    push(1, 2'd0, 40'd0);
    push(2, 2'd0, 40'd0);
    for (int i = 1; i <= 2 * P + 1; i++) begin
      step();
      exp_pc = ((i - 1) % P) + 1;
      exp_hc = (exp_pc <= MINH) ? 0 : ((exp_pc - MINH > SPAN) ? SPAN : exp_pc - MINH);
      check($sformatf("t1_pc_%0d", i), 64'(period_counter), 64'(exp_pc));
      check($sformatf("t1_fs_%0d", i), 64'(frame_start), 64'(exp_pc == P));
      check($sformatf("t1_hc_%0d", i), 64'(high_counter), 64'(exp_hc));
    end

    // T2: arm with a command already applied; ARMED after ARMF arming boundaries
    arm_req = 1'b1;
    send("t2_ready", v2);
    check("t2_pending", 64'(cmd_ready), 64'd0);
    b = bnum + 1;
    push(b, 2'd1, 40'd0);
    push(b + 1, 2'd1, 40'd0);
    push(b + 2, 2'd1, 40'd0);
    push(b + 3, 2'd2, v2);
    wait_bnum(b);
    check("t2_ready_after_apply", 64'(cmd_ready), 64'd1);
    wait_bnum(b + 3);

    // T3: second command stalls, lands at pc=1, clamps lanes 2 and 3
    goto_pc(300);
    send("t3_ready_a", va);
    goto_pc(350);
    cmd_vals  = vb;
    cmd_valid = 1'b1;
    check("t3_stall", 64'(cmd_ready), 64'd0);
    n = bnum + 1;
    push(n, 2'd2, va);
    push(n + 1, 2'd2, vbc);
    k = 0;
    while (!cmd_ready && k < P) begin
      step();
      k++;
    end
    check("t3_accept_pc", 64'(period_counter), 64'd1);
    step();
    cmd_valid = 1'b0;
    cmd_vals  = '0;

    // T4: starve commands into FAILSAFE; later commands do not re-arm
    push(n + 2, 2'd2, vbc);
    push(n + 3, 2'd3, 40'd0);
    wait_bnum(n + 3);
    send("t4_ready_c", vc);
    push(n + 4, 2'd3, 40'd0);
    wait_bnum(n + 4);
    arm_req = 1'b0;
    push(n + 5, 2'd0, 40'd0);
    wait_bnum(n + 5);

    // T5: re-arm shows last applied command; disarm mid-frame holds until boundary
    m = bnum;
    arm_req = 1'b1;
    push(m + 1, 2'd1, 40'd0);
    push(m + 2, 2'd1, 40'd0);
    push(m + 3, 2'd1, 40'd0);
    push(m + 4, 2'd2, vc);
    wait_bnum(m + 4);
    goto_pc(150);
    arm_req = 1'b0;
    goto_pc(P);
    check("t5_hold_mv", 64'(motor_vals), 64'(vc));
    check("t5_hold_state", 64'(arm_state), 64'd2);
    push(m + 5, 2'd0, 40'd0);
    wait_bnum(m + 5);

    // T6: asynchronous reset while ARMED with a command pending
    m = bnum;
    arm_req = 1'b1;
    send("t6_ready_d", vd);
    push(m + 1, 2'd1, 40'd0);
    push(m + 2, 2'd1, 40'd0);
    push(m + 3, 2'd1, 40'd0);
    push(m + 4, 2'd2, vd);
    wait_bnum(m + 4);
    goto_pc(200);
    send("t6_ready_e", ve);
    check("t6_pending", 64'(cmd_ready), 64'd0);
    goto_pc(250);
    #1;
    resetn = 1'b0;
    #1;
    check_zero_outputs("t6_reset");
    repeat (2) @(posedge us_clk);
    #1;
    check("t6_reset_hold_pc", 64'(period_counter), 64'd0);
    resetn = 1'b1;
    #1;
    check("t6_release_ready", 64'(cmd_ready), 64'd1);
    check("t6_release_mv", 64'(motor_vals), 64'd0);
    r = bnum;
    push(r + 1, 2'd1, 40'd0);
    push(r + 2, 2'd1, 40'd0);
    push(r + 3, 2'd1, 40'd0);
    push(r + 4, 2'd2, 40'd0);
    wait_bnum(r + 4);
    step();
    step();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
